// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage for the MIPS datapath.
// Holds the PC, issues one outstanding imem request at a time, presents the
// fetched word with its PC and PC+4, and picks the next PC at accept time
// from the jump / branch fields supplied by decode and the ALU zero flag.
// Optional build macro: FETCH_PERF_CNT_EN enables the perf_fetched /
// perf_stall counters; without it both outputs are tied to zero.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [15:0] MAX_WAIT = 16'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_en,
  input  logic        alu_zero,
  input  logic [15:0] branch_imm,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  output logic        fetch_err,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_ERR} state_t;

  state_t      state_reg, state_next;
  // Reset lands in S_FETCH with the request still low; this flag raises the
  // request on the first edge after reset release.
  logic        armed_reg;
  logic [15:0] wait_cnt_reg;
  logic [31:0] addr_reg, instr_reg, instr_pc_reg, pc_plus4_reg;

  logic        fetch_active, fetch_hit, fetch_miss, accept, wait_expire;
  logic [15:0] wait_inc;
  logic [31:0] branch_off, next_pc;

  assign fetch_active = (state_reg == S_FETCH) && armed_reg;
  assign fetch_hit    = fetch_active && imem_ready;
  assign fetch_miss   = fetch_active && !imem_ready;
  assign accept       = (state_reg == S_HOLD) && instr_ready;
  assign wait_inc     = wait_cnt_reg + 16'd1;
  assign wait_expire  = (MAX_WAIT != 16'd0) && (wait_inc == MAX_WAIT);
  assign branch_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: begin
        if (fetch_hit)                      state_next = S_HOLD;
        else if (fetch_miss && wait_expire) state_next = S_ERR;
      end
      S_HOLD:  if (instr_ready) state_next = S_FETCH;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_FETCH;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_req    = fetch_active;
    instr_valid = (state_reg == S_HOLD);
    fetch_err   = (state_reg == S_ERR);
  end

  // Next PC: jump beats a taken branch; only consumed at accept
  always_comb begin
    next_pc = pc_plus4_reg;
    if (jump_en)                    next_pc = {pc_plus4_reg[31:28], jump_index, 2'b00};
    else if (branch_en && alu_zero) next_pc = pc_plus4_reg + branch_off;
  end

  // Fetch address, captured instruction and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_reg    <= 1'b0;
      wait_cnt_reg <= 16'd0;
      addr_reg     <= RESET_PC;
      instr_reg    <= 32'd0;
      instr_pc_reg <= 32'd0;
      pc_plus4_reg <= 32'd0;
    end else begin
      armed_reg <= 1'b1;
      if (fetch_hit) begin
        instr_reg    <= imem_rdata;
        instr_pc_reg <= addr_reg;
        pc_plus4_reg <= addr_reg + 32'd4;
      end
      if (accept) begin
        addr_reg     <= next_pc;
        wait_cnt_reg <= 16'd0;
      end else if (fetch_miss) begin
        wait_cnt_reg <= wait_inc;
      end
    end
  end

  assign imem_addr = addr_reg;
  assign instr     = instr_reg;
  assign instr_pc  = instr_pc_reg;
  assign pc_plus4  = pc_plus4_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_reg, perf_stall_reg;

  // Performance counters: completed fetches and imem wait cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_reg <= 32'd0;
      perf_stall_reg   <= 32'd0;
    end else begin
      if (fetch_hit)  perf_fetched_reg <= perf_fetched_reg + 32'd1;
      if (fetch_miss) perf_stall_reg   <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
`else
  assign perf_fetched = 32'h0;
  assign perf_stall   = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized fetch / accept traffic against a PC model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr, instr_pc, pc_plus4;
  logic        branch_en = 1'b0;
  logic        alu_zero = 1'b0;
  logic [15:0] branch_imm = 16'h0;
  logic        jump_en = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic        fetch_err;
  logic [31:0] perf_fetched, perf_stall;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [31:0] exp_pc;
  int          n_fetched_m = 0;
  int          n_stall_m   = 0;

  pc_fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(16'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .branch_en(branch_en), .alu_zero(alu_zero), .branch_imm(branch_imm),
    .jump_en(jump_en), .jump_index(jump_index),
    .fetch_err(fetch_err),
    .perf_fetched(perf_fetched), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Architectural next PC from the MIPS rules, in plain arithmetic
  function automatic logic [31:0] model_next(input logic [31:0] pc4, input logic br,
      input logic az, input logic jp, input logic [15:0] imm, input logic [25:0] idx);
    int signed off;
    if (jp) return (pc4 & 32'hF000_0000) + (32'(idx) * 32'd4);
    if (br && az) begin
      off = int'($signed(imm)) * 4;
      return pc4 + 32'(off);
    end
    return pc4 + 32'd0;
  endfunction

  task automatic check_perf(input string tag);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_perf_fetched"}, perf_fetched, 32'(n_fetched_m));
    check({tag, "_perf_stall"}, perf_stall, 32'(n_stall_m));
`else
    check({tag, "_perf_fetched"}, perf_fetched, 32'h0);
    check({tag, "_perf_stall"}, perf_stall, 32'h0);
`endif
  endtask

  task automatic scramble_dec();
    branch_en  = 1'($urandom);
    alu_zero   = 1'($urandom);
    jump_en    = 1'($urandom);
    branch_imm = 16'($urandom);
    jump_index = 26'($urandom);
  endtask

  // One instruction: entered and left at a negedge with the DUT requesting.
  task automatic do_instr(input int stall, input int hold, input logic [31:0] word,
      input logic br, input logic az, input logic jp, input logic [15:0] imm,
      input logic [25:0] idx);
    logic [31:0] nxt;
    check("req", 32'(imem_req), 32'd1);
    check("addr", imem_addr, exp_pc);
    for (int i = 0; i < stall; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      n_stall_m++;
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", imem_addr, exp_pc);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    n_fetched_m++;
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    check("valid", 32'(instr_valid), 32'd1);
    check("req_low", 32'(imem_req), 32'd0);
    check("instr", instr, word);
    check("instr_pc", instr_pc, exp_pc);
    check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    check_perf("cap");
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'b0;
      scramble_dec();
      @(negedge clk);
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", instr, word);
      check("hold_req", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    branch_en = br; alu_zero = az; jump_en = jp; branch_imm = imm; jump_index = idx;
    nxt = model_next(exp_pc + 32'd4, br, az, jp, imm, idx);
    @(negedge clk);
    instr_ready = 1'b0;
    scramble_dec();
    check("acc_valid", 32'(instr_valid), 32'd0);
    exp_pc = nxt;
    $display("instr pc=%08h word=%08h stall=%0d br=%0b az=%0b jp=%0b -> next %08h",
             instr_pc, word, stall, br, az, jp, nxt);
  endtask

  task automatic reset_model();
    exp_pc      = RST_PC;
    n_fetched_m = 0;
    n_stall_m   = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, RST_PC);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_instr_pc"}, instr_pc, 32'd0);
    check({tag, "_pc_plus4"}, pc_plus4, 32'd0);
    check({tag, "_err"}, 32'(fetch_err), 32'd0);
    check({tag, "_perf_f"}, perf_fetched, 32'd0);
    check({tag, "_perf_s"}, perf_stall, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    imem_ready = 1'b1;
    imem_rdata = 32'h2008_0005;
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);
    // first fetch, with the same rdata the reset phase saw
    do_instr(0, 0, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);   // -> 400004
    do_instr(3, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);   // -> 400008
    do_instr(0, 2, $urandom, 1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0);     // -> 400004
    do_instr(1, 0, $urandom, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);        // -> 400008
    do_instr(0, 0, $urandom, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0);     // -> 40000C
    do_instr(2, 1, $urandom, 1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0);     // -> 400008
    do_instr(0, 0, $urandom, 1'b1, 1'b1, 1'b1, 16'hFFFE, 26'h0100004); // -> 400010
    do_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b1, 16'h0, 26'h1);        // -> 000004
    do_instr(0, 0, $urandom, 1'b1, 1'b1, 1'b0, 16'hFFFD, 26'h0);     // -> FFFFFFFC
    do_instr(1, 0, $urandom, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);        // -> 00000000
    do_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);        // -> 00000004

    for (int n = 0; n < 40; n++)
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
               1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
               16'($urandom), 26'($urandom));

    // asynchronous reset in the middle of a fetch
    imem_ready = 1'b0;
    @(negedge clk);
    n_stall_m++;
    check("pre_rst_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_instr(1, 0, $urandom, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    do_instr(0, 1, $urandom, 1'b1, 1'b1, 1'b0, 16'h0010, 26'h0);

    // imem timeout: three waits are tolerated, the fourth trips the error
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_stall_m++;
      check("tmo_err_low", 32'(fetch_err), 32'd0);
      check("tmo_req", 32'(imem_req), 32'd1);
    end
    @(negedge clk);
    n_stall_m++;
    check("tmo_err", 32'(fetch_err), 32'd1);
    check("tmo_req_low", 32'(imem_req), 32'd0);
    check("tmo_valid", 32'(instr_valid), 32'd0);
    check_perf("tmo");
    imem_ready = 1'b1;
    instr_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("sticky_err", 32'(fetch_err), 32'd1);
    check("sticky_req", 32'(imem_req), 32'd0);
    check("sticky_valid", 32'(instr_valid), 32'd0);
    instr_ready = 1'b0;

    rst_n = 1'b0;
    #1;
    check_reset_state("err_rst");
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
